// File: rtl/st_unit_if.sv
// st_unit_if
//   Data-memory write port between the store unit and memory.
//   master (store unit): drives mem_write, mem_address, mem_wdata,
//                        mem_byte_enable; samples mem_resp.
//   slave  (memory)    : the reverse.
//   mem_resp acknowledges the write currently on the bus.
interface st_unit_if;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;

  modport master (
    output mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp
  );

  modport slave (
    input  mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp
  );
endinterface

// File: rtl/st_unit.sv
// st_unit
//   Converts an RV32 store (sb/sh/sw) at any byte address into one or two
//   word-aligned memory writes with byte enables and lane-rotated data.
//   A store that straddles a word boundary is issued as two back-to-back
//   beats (low word, then next word).
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     start           : store request, accepted only in IDLE
//     store_funct3    : 000=sb, 001=sh, 010=sw; other codes complete with no write
//     addr, wdata     : byte address and rs2 data, latched on acceptance
//     mem             : memory write port (st_unit_if.master)
//     busy            : store in progress (state != IDLE)
//     done            : one-cycle completion pulse

// One output byte lane: lane i of the rotated word takes source byte (i - off) mod 4.
module st_lane #(
  parameter int LANE = 0
) (
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  output logic [7:0]  byte_o
);
  logic [1:0] src;

  always_comb begin
    src    = 2'(LANE) - off_i;
    byte_o = data_i[{src, 3'b000} +: 8];
  end
endmodule

module st_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   store_funct3,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  st_unit_if.master    mem,
  output logic         busy,
  output logic         done
);
  localparam int NUM_LANES = 4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {IDLE, WR0, WR1, FIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  // Set once beat 1 is issued so the bus keeps showing the last address used.
  logic        hi_q, hi_d;

  logic [3:0]  base_mask;
  logic [7:0]  mask8;
  logic [31:0] beat0_addr, beat1_addr;
  logic [NUM_LANES-1:0][7:0] rot_data;

  // ---------------- data / mask generation from latched copies ----------
  always_comb begin
    base_mask = 4'b0000;
    case (f3_q)
      F3_SB:   base_mask = 4'b0001;
      F3_SH:   base_mask = 4'b0011;
      F3_SW:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
    // Non-circular shift: bits that spill past lane 3 belong to the next word.
    mask8      = {4'b0000, base_mask} << addr_q[1:0];
    beat0_addr = {addr_q[31:2], 2'b00};
    beat1_addr = beat0_addr + 32'd4;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    st_lane #(.LANE(i)) u_lane (
      .data_i (wdata_q),
      .off_i  (addr_q[1:0]),
      .byte_o (rot_data[i])
    );
  end

  // ---------------- next-state / latching ---------------------------------
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d    = store_funct3;
          addr_d  = addr;
          wdata_d = wdata;
          hi_d    = 1'b0;
          if (store_funct3 == F3_SB || store_funct3 == F3_SH ||
              store_funct3 == F3_SW)
            state_d = WR0;
          else
            state_d = FIN;
        end
      end
      WR0: begin
        if (mem.mem_resp) begin
          if (mask8[7:4] != 4'b0000) begin
            state_d = WR1;
            hi_d    = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      WR1: begin
        if (mem.mem_resp) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
    end
  end

  // ---------------- outputs ----------------------------------------------
  always_comb begin
    mem.mem_write       = (state_q == WR0) || (state_q == WR1);
    mem.mem_address     = hi_q ? beat1_addr : beat0_addr;
    mem.mem_wdata       = rot_data;
    mem.mem_byte_enable = 4'b0000;
    if (state_q == WR0) mem.mem_byte_enable = mask8[3:0];
    if (state_q == WR1) mem.mem_byte_enable = mask8[7:4];
    busy = (state_q != IDLE);
    // Decoded from the state flop, so it is a clean registered pulse.
    done = (state_q == FIN);
  end
endmodule
